// File: rtl/nist_window_monitor.sv
// nist_window_monitor: windowed monobit/runs/longest-run randomness monitor with sticky flags.
// Define NIST_REPCOUNT_EN to build the continuous repetition-count test driving err_rep.
module nist_window_monitor #(
    parameter int WIN_LOG2 = 10,
    parameter int FREQ_TOL = 64,
    parameter int RUNS_MIN = 448,
    parameter int RUNS_MAX = 576,
    parameter int LRUN_MAX = 20,
    parameter int FAIL_W   = 8,
    parameter int REP_MAX  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                rnd_in,
    input  logic                rnd_valid,
    input  logic                clr_err,
    output logic                win_done,
    output logic                pass,
    output logic                err_freq,
    output logic                err_runs,
    output logic                err_lrun,
    output logic                err_rep,
    output logic [WIN_LOG2:0]   ones_cnt,
    output logic [WIN_LOG2:0]   runs_cnt,
    output logic [WIN_LOG2:0]   lrun_cnt,
    output logic [FAIL_W-1:0]   fail_cnt
);
    localparam int CW = WIN_LOG2 + 1;
    localparam int DW = WIN_LOG2 + 2;
    localparam int HALF = 2 ** (WIN_LOG2 - 1);
    localparam logic [CW-1:0] N_LAST = {1'b0, {WIN_LOG2{1'b1}}};

    typedef enum logic [1:0] {IDLE, COLLECT, EVAL} state_t;
    state_t r_state, w_next;

    logic [CW-1:0] r_bit_cnt, r_ones, r_runs, r_cur, r_max;
    logic          r_prev;
    logic          w_acc, w_last, w_first, w_diff, w_eval;
    logic [CW-1:0] w_cur_n, w_runs_n, w_max_n;
    logic signed [DW-1:0] w_dev;
    logic [DW-1:0] w_abs;
    logic          w_fail_f, w_fail_r, w_fail_l, w_fail;

    assign w_acc   = (r_state == COLLECT) && en && rnd_valid;
    assign w_last  = r_bit_cnt == N_LAST;
    assign w_first = r_bit_cnt == '0;
    assign w_diff  = rnd_in != r_prev;
    assign w_eval  = r_state == EVAL;
    assign win_done = w_eval;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = en ? COLLECT : IDLE;
            COLLECT: w_next = !en ? IDLE : (w_acc && w_last) ? EVAL : COLLECT;
            EVAL:    w_next = en ? COLLECT : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    assign w_cur_n  = (w_first || w_diff) ? CW'(1) : r_cur + 1'b1;
    assign w_runs_n = w_first ? CW'(1) : r_runs + CW'(w_diff);
    assign w_max_n  = (w_cur_n > r_max) ? w_cur_n : r_max;

    // Window counters are zero whenever not collecting, which also discards an aborted window.
    always_ff @(posedge clk) begin
        if (rst || r_state != COLLECT || !en) begin
            r_bit_cnt <= '0;
            r_ones    <= '0;
            r_runs    <= '0;
            r_cur     <= '0;
            r_max     <= '0;
            r_prev    <= 1'b0;
        end else if (rnd_valid) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
            r_ones    <= r_ones + CW'(rnd_in);
            r_runs    <= w_runs_n;
            r_cur     <= w_cur_n;
            r_max     <= w_max_n;
            r_prev    <= rnd_in;
        end
    end

    assign w_dev    = $signed({1'b0, r_ones}) - DW'(HALF);
    assign w_abs    = w_dev[DW-1] ? DW'(-w_dev) : DW'(w_dev);
    assign w_fail_f = w_abs > DW'(FREQ_TOL);
    assign w_fail_r = (r_runs < CW'(RUNS_MIN)) || (r_runs > CW'(RUNS_MAX));
    assign w_fail_l = r_max > CW'(LRUN_MAX);
    assign w_fail   = w_fail_f | w_fail_r | w_fail_l;

    // A failing evaluation overrides a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            pass     <= 1'b0;
            ones_cnt <= '0;
            runs_cnt <= '0;
            lrun_cnt <= '0;
            err_freq <= 1'b0;
            err_runs <= 1'b0;
            err_lrun <= 1'b0;
            fail_cnt <= '0;
        end else begin
            if (w_eval) begin
                pass     <= !w_fail;
                ones_cnt <= r_ones;
                runs_cnt <= r_runs;
                lrun_cnt <= r_max;
            end
            err_freq <= (err_freq & !clr_err) | (w_eval & w_fail_f);
            err_runs <= (err_runs & !clr_err) | (w_eval & w_fail_r);
            err_lrun <= (err_lrun & !clr_err) | (w_eval & w_fail_l);
            fail_cnt <= (w_eval && w_fail) ? (clr_err ? FAIL_W'(1) : (&fail_cnt) ? fail_cnt : fail_cnt + 1'b1)
                      : clr_err ? '0 : fail_cnt;
        end
    end

`ifdef NIST_REPCOUNT_EN
    localparam int RW = $clog2(REP_MAX + 1);
    logic [RW-1:0] r_rep_cnt, w_rep_n;
    logic          r_rep_prev;

    assign w_rep_n = (r_rep_cnt != '0 && rnd_in == r_rep_prev)
                   ? ((r_rep_cnt == RW'(REP_MAX)) ? r_rep_cnt : r_rep_cnt + 1'b1) : RW'(1);

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_rep_cnt  <= '0;
            r_rep_prev <= 1'b0;
        end else if (w_acc) begin
            r_rep_cnt  <= w_rep_n;
            r_rep_prev <= rnd_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) err_rep <= 1'b0;
        else     err_rep <= (err_rep & !clr_err) | (w_acc && w_rep_n == RW'(REP_MAX));
    end
`else
    assign err_rep = 1'b0;
`endif
endmodule

// File: tb/tb_nist_window_monitor.sv
// tb_nist_window_monitor: directed and randomized windows checked against a behavioural model.
module tb_nist_window_monitor;
    localparam int WL = 10, N = 1024, FT = 64, RMIN = 448, RMAX = 576, LMAX = 20, FW = 3;

    logic clk = 1'b0, rst, en, rnd_in, rnd_valid, clr_err;
    logic win_done, pass, err_freq, err_runs, err_lrun, err_rep;
    logic [WL:0] ones_cnt, runs_cnt, lrun_cnt;
    logic [FW-1:0] fail_cnt;

    int n_chk = 0, n_pass = 0;
    bit win_q[$];
    int e_ones, e_runs, e_lrun, e_fail;
    bit e_pass, e_f, e_r, e_l;

    always #5 clk = ~clk;

    nist_window_monitor #(.WIN_LOG2(WL), .FAIL_W(FW)) dut (
        .clk(clk), .rst(rst), .en(en), .rnd_in(rnd_in), .rnd_valid(rnd_valid), .clr_err(clr_err),
        .win_done(win_done), .pass(pass), .err_freq(err_freq), .err_runs(err_runs),
        .err_lrun(err_lrun), .err_rep(err_rep), .ones_cnt(ones_cnt), .runs_cnt(runs_cnt),
        .lrun_cnt(lrun_cnt), .fail_cnt(fail_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        e_ones = 0; e_runs = 0; e_lrun = 0; e_fail = 0;
        e_pass = 0; e_f = 0; e_r = 0; e_l = 0;
    endtask

    task automatic chk_outs(input string tag);
        chk({tag, ".pass"}, pass, e_pass);
        chk({tag, ".ones"}, ones_cnt, e_ones);
        chk({tag, ".runs"}, runs_cnt, e_runs);
        chk({tag, ".lrun"}, lrun_cnt, e_lrun);
        chk({tag, ".err_freq"}, err_freq, e_f);
        chk({tag, ".err_runs"}, err_runs, e_r);
        chk({tag, ".err_lrun"}, err_lrun, e_l);
        chk({tag, ".fail_cnt"}, fail_cnt, e_fail);
`ifndef NIST_REPCOUNT_EN
        chk({tag, ".err_rep"}, err_rep, 0);
`endif
    endtask

    // kind: 0 alternating from 1, 1 repeating 0011, 2 zeros, 3 ones, 4 p(one)=thr%, 5 flip p=thr%
    function automatic void fill(input int kind, input int thr);
        bit b = 0;
        win_q.delete();
        for (int i = 0; i < N; i++) begin
            case (kind)
                0: b = (i % 2 == 0);
                1: b = (i % 4 >= 2);
                2: b = 0;
                3: b = 1;
                4: b = $urandom_range(0, 99) < thr;
                default: b = b ^ ($urandom_range(0, 99) < thr);
            endcase
            win_q.push_back(b);
        end
    endfunction

    task automatic feed_window(input bit clr_at_eval, input string tag);
        int ones = 0, trans = 0, lrun = 0, cur = 0, dev;
        bit ff, fr, fl;
        for (int i = 0; i < N; i++) begin
            while ($urandom_range(0, 4) == 0) begin
                rnd_valid = 0; rnd_in = 1'($urandom_range(0, 1));
                step();
            end
            rnd_valid = 1; rnd_in = win_q[i];
            step();
            if (i == N - 2) chk({tag, ".early_done"}, win_done, 0);
        end
        chk({tag, ".win_done"}, win_done, 1);
        rnd_valid = 1; rnd_in = 1'($urandom_range(0, 1)); clr_err = clr_at_eval;
        step();
        clr_err = 0; rnd_valid = 0;
        chk({tag, ".done_pulse"}, win_done, 0);
        for (int i = 0; i < N; i++) begin
            ones += win_q[i];
            if (i > 0 && win_q[i] != win_q[i-1]) trans++;
        end
        for (int i = 0; i < N; i = i + cur) begin
            cur = 0;
            while (i + cur < N && win_q[i+cur] == win_q[i]) cur++;
            if (cur > lrun) lrun = cur;
        end
        dev = ones - N / 2;
        if (dev < 0) dev = -dev;
        ff = dev > FT; fr = (trans + 1 < RMIN) || (trans + 1 > RMAX); fl = lrun > LMAX;
        e_ones = ones; e_runs = trans + 1; e_lrun = lrun; e_pass = !(ff || fr || fl);
        if (clr_at_eval) begin
            e_f = ff; e_r = fr; e_l = fl; e_fail = (ff || fr || fl) ? 1 : 0;
        end else begin
            e_f |= ff; e_r |= fr; e_l |= fl;
            if ((ff || fr || fl) && e_fail < 2 ** FW - 1) e_fail++;
        end
        chk_outs(tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1; en = 1; rnd_valid = 0; rnd_in = 0; clr_err = 0;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            rnd_valid = 1'($urandom_range(0, 1)); rnd_in = 1'($urandom_range(0, 1));
            step();
            chk("reset.win_done", win_done, 0);
        end
        chk_outs("reset");
        rst = 0; rnd_valid = 0;
        step();

        fill(0, 0); feed_window(0, "alt");
        chk("alt.runs_const", runs_cnt, 1024);
        chk("alt.lrun_const", lrun_cnt, 1);
        fill(1, 0); feed_window(0, "p0011");
        chk("p0011.pass_const", pass, 1);
        fill(2, 0); feed_window(0, "zeros");
        chk("zeros.lrun_const", lrun_cnt, 1024);

        for (int i = 0; i < 500; i++) begin
            rnd_valid = 1; rnd_in = 1'($urandom_range(0, 1));
            step();
        end
        en = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("abort.win_done", win_done, 0);
        end
        chk_outs("abort");
        en = 1; rnd_valid = 0;
        step();
        fill(1, 0); feed_window(0, "reen");
        chk("reen.ones_const", ones_cnt, 512);

        fill(3, 0); feed_window(1, "clr_eval");
        chk("clr_eval.fail_const", fail_cnt, 1);
        clr_err = 1;
        step();
        clr_err = 0;
        e_f = 0; e_r = 0; e_l = 0; e_fail = 0;
        chk_outs("clr_only");

        for (int k = 0; k < 6; k++) begin
            fill((k % 2 == 0) ? 4 : 5, (k % 2 == 0) ? 45 + 2 * k : 40 + 3 * k);
            feed_window(0, "rand");
        end

        for (int k = 0; k < 2 ** FW; k++) begin
            fill(2, 0); feed_window(0, "sat");
        end
        chk("sat.fail_const", fail_cnt, 2 ** FW - 1);

`ifdef NIST_REPCOUNT_EN
        en = 0; step();
        clr_err = 1; step();
        clr_err = 0; en = 1; step();
        e_f = 0; e_r = 0; e_l = 0; e_fail = 0;
        chk("rep.cleared", err_rep, 0);
        for (int k = 0; k < 40; k++) begin
            rnd_valid = 0; step();
            rnd_valid = 1; rnd_in = 1; step();
            chk("rep.err_rep", err_rep, (k >= 31) ? 1 : 0);
        end
        rnd_valid = 0; en = 0; step();
        en = 1; step();
`endif

        for (int i = 0; i < 300; i++) begin
            rnd_valid = 1; rnd_in = 1'($urandom_range(0, 1));
            step();
        end
        rst = 1;
        step();
        model_reset();
        chk("mid_rst.win_done", win_done, 0);
        chk_outs("mid_rst");
        rst = 0; rnd_valid = 0;
        step();
        fill(1, 0); feed_window(0, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
